box_anim_datapath: RTL and testbench

- Datapath that answers the bouncing-box animation controller.
- Consumes the controller's one-hot load strobes (draw / wait / erase / move).
- Returns the three status handshakes the controller waits on: done, enable, update.
- Drives pixel x, y and colour to the 160x120 VGA adapter. The controller's plot output goes to the adapter directly and is not an input here.

---
 rtl/anim_pkg.sv | 31 +++
 rtl/rate_divider.sv | 31 +++
 rtl/box_anim_datapath.sv | 120 ++++++++++++
 tb/tb_box_anim_datapath.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/anim_pkg.sv
// Shared constants and strobe decoding for the bouncing-box animation datapath.
package anim_pkg;

    localparam int unsigned X_MAX        = 160;
    localparam int unsigned Y_MAX        = 120;
    localparam int unsigned XW           = 8;
    localparam int unsigned YW           = 7;
    localparam int unsigned CW           = 3;
    localparam int unsigned BOX_SIZE_DEF = 4;

    localparam logic [CW-1:0] BLACK = '0;

    typedef enum logic [2:0] {
        STRB_NONE,
        STRB_DRAW,
        STRB_ERASE,
        STRB_WAIT,
        STRB_MOVE
    } strobe_e;

    // Strobes should be one-hot; if not, draw > erase > wait > move.
    function automatic strobe_e pick_strobe(input logic draw, input logic erase,
                                            input logic wait_, input logic move);
        if (draw)       return STRB_DRAW;
        else if (erase) return STRB_ERASE;
        else if (wait_) return STRB_WAIT;
        else if (move)  return STRB_MOVE;
        else            return STRB_NONE;
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Reloadable down-counter: pulses enable_o on the WAIT_CYCLES-th consecutive en_i cycle.
module rate_divider #(
    parameter int unsigned WAIT_CYCLES = 12500000
) (
    input  logic clk,
    input  logic resetn,
    input  logic en_i,
    output logic enable_o
);

    localparam int unsigned CNTW = $clog2(WAIT_CYCLES);
    localparam logic [CNTW-1:0] RELOAD = CNTW'(WAIT_CYCLES - 1);

    logic [CNTW-1:0] cnt_q, cnt_d;

    assign enable_o = en_i && (cnt_q == '0);

    always_comb begin
        cnt_d = RELOAD;
        if (en_i && (cnt_q != '0))
            cnt_d = cnt_q - CNTW'(1);
    end

    always_ff @(posedge clk) begin
        if (!resetn)
            cnt_q <= RELOAD;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/box_anim_datapath.sv
// Datapath for the bouncing-box animation: pixel scan, wait timer and
// one-step-per-visit box movement with edge bounce.
module box_anim_datapath #(
    parameter int unsigned BOX_SIZE    = anim_pkg::BOX_SIZE_DEF,
    parameter int unsigned WAIT_CYCLES = 12500000,
    parameter int unsigned X_MAX       = anim_pkg::X_MAX,
    parameter int unsigned Y_MAX       = anim_pkg::Y_MAX,
    parameter int unsigned X_START     = 0,
    parameter int unsigned Y_START     = 0
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       ld_draw,
    input  logic       ld_wait,
    input  logic       ld_erase,
    input  logic       ld_move,
    input  logic [2:0] colour_in,
    output logic       done,
    output logic       enable,
    output logic       update,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour
);

    import anim_pkg::*;

    localparam int unsigned PIX = BOX_SIZE * BOX_SIZE;
    localparam int unsigned PW  = $clog2(PIX);
    localparam int unsigned HW  = PW / 2;

    localparam logic [PW-1:0] PIX_LAST = PW'(PIX - 1);
    localparam logic [XW-1:0] X_EDGE   = XW'(X_MAX - BOX_SIZE);
    localparam logic [YW-1:0] Y_EDGE   = YW'(Y_MAX - BOX_SIZE);

    strobe_e sel;
    logic    scan;

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [XW-1:0] bx_q, bx_d;
    logic [YW-1:0] by_q, by_d;
    logic          dir_x_q, dir_x_d;
    logic          dir_y_q, dir_y_d;
    logic          move_done_q, move_done_d;

    assign sel  = pick_strobe(ld_draw, ld_erase, ld_wait, ld_move);
    assign scan = ld_draw || ld_erase;

    // Low half of pcnt walks across a row, high half walks down the rows.
    assign x      = bx_q + XW'(pcnt_q[HW-1:0]);
    assign y      = by_q + YW'(pcnt_q[PW-1:HW]);
    assign done   = scan && (pcnt_q == PIX_LAST);
    assign colour = (sel == STRB_DRAW) ? colour_in : BLACK;
    assign update = move_done_q;

    rate_divider #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_rate_divider (
        .clk     (clk),
        .resetn  (resetn),
        .en_i    (sel == STRB_WAIT),
        .enable_o(enable)
    );

    always_comb begin
        pcnt_d      = '0;
        bx_d        = bx_q;
        by_d        = by_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        move_done_d = 1'b0;

        if (scan)
            pcnt_d = pcnt_q + PW'(1);

        if (sel == STRB_MOVE) begin
            move_done_d = 1'b1;
            if (!move_done_q) begin
                if (dir_x_q && (bx_q == X_EDGE)) begin
                    dir_x_d = 1'b0;
                    bx_d    = bx_q - XW'(1);
                end else if (!dir_x_q && (bx_q == '0)) begin
                    dir_x_d = 1'b1;
                    bx_d    = XW'(1);
                end else begin
                    bx_d = dir_x_q ? bx_q + XW'(1) : bx_q - XW'(1);
                end

                if (dir_y_q && (by_q == Y_EDGE)) begin
                    dir_y_d = 1'b0;
                    by_d    = by_q - YW'(1);
                end else if (!dir_y_q && (by_q == '0)) begin
                    dir_y_d = 1'b1;
                    by_d    = YW'(1);
                end else begin
                    by_d = dir_y_q ? by_q + YW'(1) : by_q - YW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pcnt_q      <= '0;
            bx_q        <= XW'(X_START);
            by_q        <= YW'(Y_START);
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            move_done_q <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            bx_q        <= bx_d;
            by_q        <= by_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            move_done_q <= move_done_d;
        end
    end

endmodule

// File: tb/tb_box_anim_datapath.sv
// Self-checking bench: two datapath instances (start at origin / start at the far corner)
// driven by shared directed and random strobes, compared against a behavioural model.
module tb_box_anim_datapath;

    localparam int W   = 4;
    localparam int B   = 4;
    localparam int XE  = 160 - B;
    localparam int YE  = 120 - B;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       ld_draw = 1'b0, ld_wait = 1'b0, ld_erase = 1'b0, ld_move = 1'b0;
    logic [2:0] colour_in = '0;

    logic       done0, enable0, update0, done1, enable1, update1;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic [2:0] colour0, colour1;

    box_anim_datapath #(
        .BOX_SIZE(B), .WAIT_CYCLES(W), .X_MAX(160), .Y_MAX(120), .X_START(0), .Y_START(0)
    ) dut (
        .clk(clk), .resetn(resetn), .ld_draw(ld_draw), .ld_wait(ld_wait),
        .ld_erase(ld_erase), .ld_move(ld_move), .colour_in(colour_in),
        .done(done0), .enable(enable0), .update(update0),
        .x(x0), .y(y0), .colour(colour0)
    );

    box_anim_datapath #(
        .BOX_SIZE(B), .WAIT_CYCLES(W), .X_MAX(160), .Y_MAX(120), .X_START(XE), .Y_START(YE)
    ) dut_edge (
        .clk(clk), .resetn(resetn), .ld_draw(ld_draw), .ld_wait(ld_wait),
        .ld_erase(ld_erase), .ld_move(ld_move), .colour_in(colour_in),
        .done(done1), .enable(enable1), .update(update1),
        .x(x1), .y(y1), .colour(colour1)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Model state: box position per instance, progress within a pass,
    // consecutive effective wait cycles, and whether this move visit has stepped.
    int mbx[2], mby[2];
    bit mdx[2], mdy[2];
    int k, r;
    bit visited;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        mbx[0] = 0;  mby[0] = 0;
        mbx[1] = XE; mby[1] = YE;
        for (int i = 0; i < 2; i++) begin mdx[i] = 1; mdy[i] = 1; end
        k = 0; r = 0; visited = 0;
    endtask

    task automatic bounce(inout int p, inout bit d, input int edge_);
        if (d && p == edge_)      begin d = 0; p = p - 1; end
        else if (!d && p == 0)    begin d = 1; p = 1; end
        else                      p = d ? p + 1 : p - 1;
    endtask

    // One clock cycle: drive, check outputs mid-cycle, advance the model past the edge.
    task automatic cyc(input bit rst, input bit d, input bit w, input bit e, input bit m,
                       input logic [2:0] col);
        bit scan, effw, effm;
        resetn = ~rst; ld_draw = d; ld_wait = w; ld_erase = e; ld_move = m; colour_in = col;
        scan = d | e;
        effw = w & ~d & ~e;
        effm = m & ~d & ~e & ~w;
        #3;
        if (!rst) begin
            chk("done",    32'(done0),   32'(scan && k == B*B-1));
            chk("enable",  32'(enable0), 32'(effw && r == W-1));
            chk("update",  32'(update0), 32'(visited));
            chk("colour",  32'(colour0), d ? 32'(col) : 32'd0);
            chk("x",       32'(x0),      32'(mbx[0] + k % B));
            chk("y",       32'(y0),      32'(mby[0] + k / B));
            chk("edge_x",  32'(x1),      32'(mbx[1] + k % B));
            chk("edge_y",  32'(y1),      32'(mby[1] + k / B));
            chk("edge_upd", 32'(update1), 32'(visited));
            chk("edge_done", 32'({done1, enable1}), 32'({done0, enable0}));
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            k = scan ? (k + 1) % (B*B) : 0;
            r = effw ? (r + 1) % W : 0;
            if (effm && !visited)
                for (int i = 0; i < 2; i++) begin
                    bounce(mbx[i], mdx[i], XE);
                    bounce(mby[i], mdy[i], YE);
                end
            visited = effm;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 3'($urandom));
    endtask

    initial begin
        model_reset();
        @(posedge clk); #1;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 1, 1, 1, 1, 3'b111);
        idle(1);

        for (int i = 0; i < 16; i++) cyc(0, 1, 0, 0, 0, 3'b101);
        idle(1);

        for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 0, 0, 0);
        idle(1);

        for (int i = 0; i < 2; i++) cyc(0, 0, 0, 0, 1, 0);
        idle(1);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 0, 3'b110);
        idle(1);

        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0);
        idle(1);

        for (int v = 0; v < 170; v++) begin
            cyc(0, 0, 0, 0, 1, 0);
            idle(1);
        end

        for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 0, 3'b011);
        cyc(1, 1, 0, 0, 0, 3'b011);
        idle(1);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0, 3'b010);
        for (int i = 0; i < W; i++) cyc(0, 0, 1, 0, 0, 0);

        for (int burst = 0; burst < 300; burst++) begin
            int sel, len;
            bit d, w, e, m;
            sel = int'($urandom_range(0, 9));
            len = int'($urandom_range(1, 20));
            {d, w, e, m} = 4'b0000;
            case (sel)
                1, 2: d = 1;
                3, 4: e = 1;
                5, 6: w = 1;
                7, 8: m = 1;
                9:    {d, w, e, m} = 4'($urandom);
                default: ;
            endcase
            for (int i = 0; i < len; i++)
                cyc(($urandom_range(0, 199) == 0), d, w, e, m, 3'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
